wb_regfile: RTL
===============

# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs and selects the writeback value from ALU result, load data or PC+4. Commits that value to a 32-entry register file and serves the two ID-stage read ports, with same-cycle write-to-read bypass. Also exports the writeback value for EX forwarding and a committed-write counter for performance and debug.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- CNT_W, 32, width of the committed-write counter

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- mem_to_reg  in  2  writeback source select: 00 ALU, 01 load data, 10 PC+4, 11 ALU
- reg_write  in  1  writeback enable from MEM/WB
- wb_dst  in  5  destination register index
- read_data  in  DATA_W  load data from MEM/WB
- alu_result  in  DATA_W  ALU result from MEM/WB
- pc_plus4  in  DATA_W  link address from MEM/WB (jal)
- rs_addr  in  5  ID read port A index
- rt_addr  in  5  ID read port B index
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- wb_data  out  DATA_W  selected writeback value, combinational, for EX forwarding
- wb_valid  out  1  reg_write && wb_dst != 0, combinational
- write_count  out  CNT_W  number of committed register writes, registered

## Operation
- Writeback mux: wb_data = alu_result (00), read_data (01), pc_plus4 (10), alu_result (11, reserved). The mux is purely combinational from the current inputs.
- Storage: 32 x DATA_W registers, r0..r31.
- Write: on rising clk, if !rst && reg_write && wb_dst != 0, then reg[wb_dst] <= wb_data.
- Writes with wb_dst == 0 are discarded. r0 always reads 0, including after reset and via bypass.
- Read port A:
  - rs_addr == 0: output 0.
  - Else if wb_valid && wb_dst == rs_addr: output wb_data (bypass).
  - Else: output reg[rs_addr].
- Read port B: same rule using rt_addr.
- Both ports may address the same register, or the writeback register, in the same cycle; each resolves independently by the rule above.
- Counter: on rising clk, if !rst && wb_valid, write_count <= write_count + 1, modulo 2^CNT_W. All-ones wraps to 0. No saturation and no overflow flag.
- Reset: on rising clk with rst=1, all 32 registers <= 0 and write_count <= 0. rst has priority over any write in the same cycle; that write is lost.

## Timing
- Reset values: every register 0 and write_count 0.
  - rs_data, rt_data: 0 after reset unless bypassed.
  - wb_data, wb_valid: combinational from inputs, no reset value.
- Write latency: value is in the array at the edge ending the cycle where reg_write is asserted. Array reads see it from the next cycle.
- Bypass latency: 0 cycles; the ID-stage read in the same cycle returns the new value. The pipeline needs no split-cycle (negedge) write.
- rs_data and rt_data have a combinational path from rs_addr, rt_addr, wb_dst, reg_write, mem_to_reg and the three data inputs.
- write_count updates one edge after the qualifying cycle and is observable the cycle after.
- Reset mid-stream: a write presented while rst=1 is not committed and not counted. The first write after rst deasserts commits normally.
- Back-to-back writes to the same register: the last write wins. A read in the same cycle as the second write returns the second value via bypass.

## Test plan
- Reset: assert rst 2 cycles, deassert. Read all 32 indices -> every rs_data/rt_data = 0; write_count = 0.
- ALU writeback: reg_write=1, mem_to_reg=00, wb_dst=5, alu_result=0x1234_5678. Next cycle rs_addr=5 -> 0x1234_5678; write_count=1.
- Source select:
  - mem_to_reg=01, read_data=0xDEAD_BEEF, wb_dst=8 -> r8=0xDEAD_BEEF.
  - mem_to_reg=10, pc_plus4=0x0000_0040, wb_dst=31 -> r31=0x40.
  - mem_to_reg=11 -> value written equals alu_result.
- Bypass and r0:
  - Same cycle: write 0xAAAA_0001 to r9, rs_addr=rt_addr=9 -> both ports 0xAAAA_0001 before the edge.
  - Write 0xFFFF_FFFF to r0 -> rs_addr=0 reads 0 in that cycle and after; wb_valid=0; write_count unchanged.
- Reset priority: rst=1 and reg_write=1 (r3 <= 7) in the same cycle -> r3=0 and write_count=0 afterward.
- Counter wrap: with CNT_W=4, perform 17 valid writes -> write_count sequence ends 15, 0, 1.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry architectural register file for the 5-stage pipeline.
// Selects the writeback value, commits it, and serves two ID read ports with same-cycle bypass.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_to_reg,
    input  logic              reg_write,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  write_count
);

    logic [DATA_W-1:0] regs [32];

    always_comb begin
        case (mem_to_reg)
            2'b01:   wb_data = read_data;
            2'b10:   wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    assign wb_valid = reg_write && (wb_dst != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (wb_valid) begin
            regs[wb_dst] <= wb_data;
            write_count  <= write_count + CNT_W'(1);
        end
    end

    // Bypass gives the ID stage the committing value without a split-cycle write.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = '0;
        end else if (wb_valid && (wb_dst == rs_addr)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = '0;
        end else if (wb_valid && (wb_dst == rt_addr)) begin
            rt_data = wb_data;
        end
    end

endmodule
